clock_divider_multi: RTL and testbench

Parametrised multi-channel successor to the fixed two-output clock divider. Each of NUM_CH channels produces a divided clock-enable/square wave with runtime-programmable period and high time. Reloads take effect only at the period boundary, so outputs never glitch. A global sync restarts all channels phase-aligned. Sits between the board clock and slow peripherals: display scan, debounce, LED blink.

---
 rtl/clock_divider_multi.sv | 94 +++++++++
 tb/tb_clock_divider_multi.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel period/high time with shadowed
// reloads that land only on period boundaries, plus a global phase-aligning sync.
module clock_divider_multi #(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = 16,
   parameter int DEF_PERIOD = 1200,
   parameter int DEF_HIGH   = 600
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              ld,
   input  logic [NUM_CH-1:0] ld_mask,
   input  logic [CNT_W-1:0]  period_in,
   input  logic [CNT_W-1:0]  high_in,
   input  logic              sync,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending
);

   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

   // Periods of 0 or 1 cannot form a square wave; clamp to the shortest legal period.
   function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W-1:0] p);
      return (p < CNT_W'(2)) ? CNT_W'(2) : p;
   endfunction

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt, per_act, hi_act, per_sh, hi_sh;
      logic [CNT_W-1:0] cnt_n, per_n, hi_n, per_sh_n, hi_sh_n, p_eff;
      logic             pend, run, pend_n, run_n, ld_i;
      logic             clk_r, tick_r;

      always_comb begin
         ld_i     = ld & ld_mask[i];
         p_eff    = sat_period(per_act);
         per_sh_n = ld_i ? period_in : per_sh;
         hi_sh_n  = ld_i ? high_in : hi_sh;
         pend_n   = pend | ld_i;
         per_n    = per_act;
         hi_n     = hi_act;
         run_n    = en[i];
         cnt_n    = cnt + CNT_W'(1);
         if (!en[i]) begin
            cnt_n = '0;
            // Idle channel: an older pending load moves straight into the active set.
            if (pend && !ld_i) begin
               per_n  = per_sh;
               hi_n   = hi_sh;
               pend_n = 1'b0;
            end
         end else if (!run || sync || (cnt >= p_eff - CNT_W'(1))) begin
            cnt_n = '0;
            if (pend_n) begin
               per_n  = per_sh_n;
               hi_n   = hi_sh_n;
               pend_n = 1'b0;
            end
         end
      end

      // Outputs are derived from the next count so they line up with the registered cnt.
      always_ff @(posedge Clk or posedge Rst) begin
         if (Rst) begin
            cnt     <= '0;
            per_act <= DEF_P;
            hi_act  <= DEF_H;
            per_sh  <= DEF_P;
            hi_sh   <= DEF_H;
            pend    <= 1'b0;
            run     <= 1'b0;
            clk_r   <= 1'b0;
            tick_r  <= 1'b0;
         end else begin
            cnt     <= cnt_n;
            per_act <= per_n;
            hi_act  <= hi_n;
            per_sh  <= per_sh_n;
            hi_sh   <= hi_sh_n;
            pend    <= pend_n;
            run     <= run_n;
            clk_r   <= run_n & (cnt_n < hi_n);
            tick_r  <= run_n & (cnt_n == '0);
         end
      end

      assign clk_out[i] = clk_r;
      assign tick[i]    = tick_r;
      assign pending[i] = pend;
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: a time-based reference model checked every
// cycle, plus hand-computed waveform landmarks.
module tb_clock_divider_multi;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 16;
   localparam int DEF_PERIOD = 1200;
   localparam int DEF_HIGH   = 600;

   logic              Clk = 1'b0;
   logic              Rst = 1'b1;
   logic [NUM_CH-1:0] en = '0;
   logic              ld = 1'b0;
   logic [NUM_CH-1:0] ld_mask = '0;
   logic [CNT_W-1:0]  period_in = '0;
   logic [CNT_W-1:0]  high_in = '0;
   logic              sync = 1'b0;
   logic [NUM_CH-1:0] clk_out, tick, pending;

   int tests = 0;
   int fails = 0;

   clock_divider_multi #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .DEF_HIGH(DEF_HIGH)
   ) dut (
      .Clk(Clk), .Rst(Rst), .en(en), .ld(ld), .ld_mask(ld_mask),
      .period_in(period_in), .high_in(high_in), .sync(sync),
      .clk_out(clk_out), .tick(tick), .pending(pending)
   );

   always #5 Clk = ~Clk;

   // Reference model: each channel remembers the cycle its current period began.
   int t = 0;
   int start [NUM_CH];
   int pa [NUM_CH], ha [NUM_CH], ps [NUM_CH], hs [NUM_CH];
   bit pend [NUM_CH], run [NUM_CH];
   logic [NUM_CH-1:0] exp_clk, exp_tick, exp_pend;

   function automatic int peff(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, req, t);
      end
   endtask

   task automatic model_step();
      bit ldc;
      t++;
      for (int c = 0; c < NUM_CH; c++) begin
         ldc = ld && ld_mask[c];
         if (Rst) begin
            pa[c] = DEF_PERIOD; ha[c] = DEF_HIGH; ps[c] = DEF_PERIOD; hs[c] = DEF_HIGH;
            pend[c] = 0; run[c] = 0; start[c] = t;
         end else if (!en[c]) begin
            run[c] = 0; start[c] = t;
            if (pend[c] && !ldc) begin pa[c] = ps[c]; ha[c] = hs[c]; pend[c] = 0; end
            if (ldc) begin ps[c] = period_in; hs[c] = high_in; pend[c] = 1; end
         end else begin
            if (ldc) begin ps[c] = period_in; hs[c] = high_in; pend[c] = 1; end
            if (!run[c] || sync || (t - start[c]) >= peff(pa[c])) begin
               start[c] = t;
               if (pend[c]) begin pa[c] = ps[c]; ha[c] = hs[c]; pend[c] = 0; end
            end
            run[c] = 1;
         end
         exp_clk[c]  = run[c] && ((t - start[c]) < ha[c]);
         exp_tick[c] = run[c] && (t == start[c]);
         exp_pend[c] = pend[c];
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      @(posedge Clk);
      model_step();
      #1;
      chk("clk_out", 32'(clk_out), 32'(exp_clk));
      chk("tick", 32'(tick), 32'(exp_tick));
      chk("pending", 32'(pending), 32'(exp_pend));
   endtask

   task automatic load(input logic [NUM_CH-1:0] m, input int p, input int h);
      ld = 1'b1; ld_mask = m; period_in = CNT_W'(p); high_in = CNT_W'(h);
   endtask

   initial begin
      int n, hi_cnt, tk_cnt, both;
      logic [3:0] seq;
      for (int c = 0; c < NUM_CH; c++) begin
         pa[c] = DEF_PERIOD; ha[c] = DEF_HIGH; ps[c] = DEF_PERIOD; hs[c] = DEF_HIGH;
         pend[c] = 0; run[c] = 0; start[c] = 0;
      end

      // Reset state
      repeat (3) step();
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      Rst = 1'b0;
      repeat (2) step();
      chk("disabled_out", 32'(clk_out | tick), 32'd0);

      // Defaults: first enabled cycle ticks with output high
      en = 2'b11;
      step();
      chk("first_en_tick", 32'(tick), 32'h3);
      chk("first_en_clk", 32'(clk_out), 32'h3);
      repeat (100) step();

      // Reload ch0 at cnt=100; it must finish the 1200 period first
      load(2'b01, 10, 3);
      step();
      ld = 1'b0;
      chk("ld_pending", 32'(pending), 32'h1);
      n = 0;
      for (int k = 0; k < 1300; k++) begin
         step();
         n++;
         if (tick[0]) break;
      end
      chk("old_period_tail", 32'(n), 32'd1099);
      chk("wrap_both_tick", 32'(tick), 32'h3);
      chk("wrap_pending", 32'(pending), 32'h0);
      hi_cnt = 0; tk_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         hi_cnt += int'(clk_out[0]);
         tk_cnt += int'(tick[0]);
      end
      chk("p10_high_cnt", 32'(hi_cnt), 32'd9);
      chk("p10_tick_cnt", 32'(tk_cnt), 32'd3);

      // ch1 clamped period: load while idle, then re-enable
      en = 2'b01;
      load(2'b10, 1, 1);
      step();
      ld = 1'b0;
      step();
      chk("idle_transfer", 32'(pending[1]), 32'd0);
      en = 2'b11;
      seq = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         seq = {seq[2:0], clk_out[1]};
      end
      chk("p2_toggle", 32'(seq), 32'hA);
      load(2'b10, 1, 0);
      step();
      ld = 1'b0;
      repeat (3) step();
      hi_cnt = 0; tk_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         hi_cnt += int'(clk_out[1]);
         tk_cnt += int'(tick[1]);
      end
      chk("h0_high_cnt", 32'(hi_cnt), 32'd0);
      chk("h0_tick_cnt", 32'(tk_cnt), 32'd3);
      load(2'b10, 1, 5);
      step();
      ld = 1'b0;
      repeat (3) step();
      hi_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         hi_cnt += int'(clk_out[1]);
      end
      chk("h5_high_cnt", 32'(hi_cnt), 32'd6);

      // Periods 10 and 15, staggered, then sync
      en = 2'b00;
      load(2'b01, 10, 5);
      step();
      load(2'b10, 15, 7);
      step();
      ld = 1'b0;
      step();
      en = 2'b01;
      repeat (3) step();
      en = 2'b11;
      repeat (7) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_tick", 32'(tick), 32'h3);
      both = 0;
      for (int k = 0; k < 29; k++) begin
         step();
         if (tick == 2'b11) both++;
      end
      chk("no_early_align", 32'(both), 32'd0);
      step();
      chk("align_30", 32'(tick), 32'h3);

      // ld together with sync: new values apply immediately
      load(2'b11, 8, 4);
      sync = 1'b1;
      step();
      ld = 1'b0; sync = 1'b0;
      chk("ldsync_pending", 32'(pending), 32'h0);
      chk("ldsync_tick", 32'(tick), 32'h3);
      chk("ldsync_clk", 32'(clk_out), 32'h3);
      repeat (3) step();
      chk("p8_cnt3_high", 32'(clk_out), 32'h3);
      step();
      chk("p8_cnt4_low", 32'(clk_out), 32'h0);
      repeat (4) step();
      chk("p8_wrap_tick", 32'(tick), 32'h3);

      // Reset mid-period with a pending load
      load(2'b01, 20, 10);
      step();
      ld = 1'b0;
      chk("pre_rst_pending", 32'(pending), 32'h1);
      repeat (2) step();
      Rst = 1'b1;
      #1;
      chk("async_rst_clk", 32'(clk_out), 32'h0);
      chk("async_rst_tick", 32'(tick), 32'h0);
      chk("async_rst_pending", 32'(pending), 32'h0);
      repeat (2) step();
      Rst = 1'b0;
      step();
      chk("post_rst_tick", 32'(tick), 32'h3);
      hi_cnt = 1;
      for (int k = 1; k < 1200; k++) begin
         step();
         hi_cnt += int'(clk_out[0]);
      end
      chk("post_rst_high", 32'(hi_cnt), 32'd600);
      step();
      chk("post_rst_period", 32'(tick), 32'h3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
